// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the programmable serial pattern detector.
// Reset defaults reproduce the classic overlapping 1011 detector.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    FILL,
    ARMED,
    HIT
  } seqdet_state_t;

  localparam int         DEFAULT_MAX_LEN = 8;
  localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1011;
  localparam int         DEFAULT_LEN     = 4;
  localparam bit         DEFAULT_OVERLAP = 1'b1;

  // Width needed to hold a length value 0..max_len inclusive.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_detect_cmp.sv
// Combinational masked compare: the low `len` bits of hist against pattern.
module seq_detect_cmp #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] mask;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign hit = ((hist ^ pattern) & mask) == '0;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with runtime pattern/length/overlap,
// registered Moore match flag and saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int                 MAX_LEN       = DEFAULT_MAX_LEN,
  parameter int                 CNT_W         = 16,
  parameter logic [MAX_LEN-1:0] RESET_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
  parameter int                 RESET_LEN     = DEFAULT_LEN,
  parameter bit                 RESET_OVERLAP = DEFAULT_OVERLAP,
  localparam int                LEN_W         = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               clr_count,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  seqdet_state_t      state;
  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               accept;
  logic               cfg_ok;
  logic               cmp_hit;
  logic               hit;

  // A configuration write on the same edge drops the incoming bit.
  assign accept    = in_valid && !cfg_we;
  assign cfg_ok    = (cfg_len != '0) && (cfg_len <= MAX_FILL);
  assign hist_next = {hist[MAX_LEN-2:0], in_bit};
  assign fill_next = (fill == MAX_FILL) ? fill : fill + 1'b1;

  seq_detect_cmp #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_cmp (
    .hist   (hist_next),
    .pattern(pattern),
    .len    (len),
    .hit    (cmp_hit)
  );

  assign hit = accept && cmp_hit && (fill_next >= len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      hist  <= '0;
      fill  <= '0;
      out   <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_ok) begin
        state <= FILL;
        hist  <= '0;
        fill  <= '0;
        out   <= 1'b0;
      end
    end else if (accept) begin
      hist <= hist_next;
      if (hit) begin
        state <= HIT;
        out   <= 1'b1;
        // Non-overlap mode demands `len` fresh bits before the next match.
        fill  <= overlap ? fill_next : '0;
      end else begin
        state <= (fill_next >= len) ? ARMED : FILL;
        out   <= 1'b0;
        fill  <= fill_next;
      end
    end else begin
      out <= (state == HIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern <= RESET_PATTERN;
      len     <= LEN_W'(RESET_LEN);
      overlap <= RESET_OVERLAP;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        overlap <= cfg_overlap;
        cfg_err <= 1'b0;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Clear takes priority, then a same-edge match still counts once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_count <= '0;
    end else if (clr_count) begin
      match_count <= hit ? CNT_W'(1) : '0;
    end else if (hit && (match_count != CNT_MAX)) begin
      match_count <= match_count + 1'b1;
    end
  end

endmodule
